// File: rtl/mips_mem_pkg.sv
// Shared encodings, FSM states and the latched request payload for the load/store unit.
package mips_mem_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 1000;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    RMW_READ,
    RMW_WRITE
  } lsu_state_e;

  // Only the low halfword of store data is needed after acceptance (sub-word stores).
  typedef struct packed {
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [15:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and store read-modify-write merge.
module lsu_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data_c,
  output logic [31:0] merged_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v      = 8'(rdata >> {lane, 3'b000});
    half_v      = 16'(rdata >> {lane[1], 4'b0000});
    load_data_c = rdata;
    merged_c    = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data_c = is_unsigned ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
        merged_c    = rdata;
        merged_c[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        load_data_c = is_unsigned ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
        merged_c    = rdata;
        merged_c[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: aligned loads, word stores and sub-word read-modify-write.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        range_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] word_idx;
  logic [31:0] q_word_idx;
  logic        bad_align;
  logic        out_of_range;
  logic [31:0] extract;
  logic [31:0] merged;

  assign word_idx     = {2'b00, req_addr[31:2]};
  assign q_word_idx   = {2'b00, req_q.addr[31:2]};
  assign bad_align    = (req_size == SIZE_ILL)
                     || ((req_size == SIZE_HALF) && req_addr[0])
                     || ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
  assign out_of_range = word_idx >= 32'(MEM_WORDS);

  lsu_align u_align (
    .rdata       (mem_rdata),
    .wdata       ({16'b0, req_q.wdata}),
    .lane        (req_q.addr[1:0]),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .load_data_c (extract),
    .merged_c    (merged)
  );

  // State, latched request and merge word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      merge_q <= merge_d;
    end
  end

  // Next state and strobes; the IDLE decode is gated by rst_n so reset zeroes every output
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    merge_d     = merge_q;
    stall       = 1'b0;
    load_valid  = 1'b0;
    load_data   = '0;
    misalign    = 1'b0;
    range_err   = 1'b0;
    mem_address = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && rst_n) begin
          mem_address = word_idx;
          if (bad_align) begin
            misalign = 1'b1;
          end else if (out_of_range) begin
            range_err = 1'b1;
          end else if (req_write && (req_size == SIZE_WORD)) begin
            mem_write = 1'b1;
            mem_wdata = req_wdata;
          end else begin
            mem_read = 1'b1;
            stall    = 1'b1;
            req_d    = '{size: req_size, is_unsigned: req_unsigned,
                         addr: req_addr, wdata: req_wdata[15:0]};
            state_d  = req_write ? RMW_READ : LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        mem_address = q_word_idx;
        load_valid  = 1'b1;
        load_data   = extract;
        state_d     = IDLE;
      end
      RMW_READ: begin
        mem_address = q_word_idx;
        stall       = 1'b1;
        merge_d     = merged;
        state_d     = RMW_WRITE;
      end
      RMW_WRITE: begin
        mem_address = q_word_idx;
        mem_write   = 1'b1;
        mem_wdata   = merge_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1000: word depth of the data memory; word indices >= MEM_WORDS are out of range.
REQ-002 SHALL have one clock and an asynchronous, active-low reset; ports are listed below as name, direction, width, meaning.
REQ-003 Clk  in  1  rising-edge clock shared with data memory.
REQ-004 Rst_n  in  1  asynchronous active-low reset.
REQ-005 Req_valid  in  1  MEM-stage access request.
REQ-006 Req_write  in  1  1=store, 0=load.
REQ-007 Req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-008 Req_unsigned  in  1  zero-extend load (lbu/lhu) when 1.
REQ-009 Req_addr  in  32  byte address.
REQ-010 Req_wdata  in  32  store data, right-justified.
REQ-011 Stall  out  1  pipeline hold.
REQ-012 Load_valid  out  1  load result valid this cycle.
REQ-013 Load_data  out  32  extended load result; 0 when Load_valid=0.
REQ-014 Misalign  out  1  one-cycle pulse: misaligned or illegal-size request, dropped.
REQ-015 Range_err  out  1  one-cycle pulse: word index >= MEM_WORDS, request dropped.
REQ-016 Mem_address  out  32  word index = {2'b00, Req_addr[31:2]}.
REQ-017 Mem_read, Mem_write  out  1 each  memory strobes, never both high.
REQ-018 Mem_wdata  out  32  write word.
REQ-019 Mem_rdata  in  32  memory read word, valid the cycle after Mem_read is sampled.

Function
REQ-020 States SHALL be IDLE, LOAD_WAIT, RMW_READ, RMW_WRITE; the request is accepted only in IDLE and latched on acceptance.
REQ-021 Little-endian lanes: byte lane = Req_addr[1:0]; halfword lane = Req_addr[1].
REQ-022 Checks in IDLE: half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> Misalign; else index >= MEM_WORDS -> Range_err; either case: no strobes, no stall, stay IDLE; Misalign has priority.
REQ-023 Word store: in IDLE, Mem_write=1, Mem_wdata=Req_wdata, Stall=0, remain IDLE (1 cycle).
REQ-024 Load: IDLE Mem_read=1, Stall=1 -> LOAD_WAIT; LOAD_WAIT Load_valid=1, Load_data=lane extracted from Mem_rdata, sign- or zero-extended, Stall=0 -> IDLE (2 cycles).
REQ-025 Sub-word store: IDLE Mem_read=1, Stall=1 -> RMW_READ; RMW_READ registers Mem_rdata merged with the latched data lane, Stall=1 -> RMW_WRITE; RMW_WRITE Mem_write=1, Mem_wdata=merged word, Stall=0 -> IDLE (3 cycles).
REQ-026 Outside IDLE, Mem_address SHALL come from the latched request; Req_* changes during Stall are ignored.
REQ-027 Req_valid=0 in IDLE: all outputs 0, no state change.

Reset
REQ-028 Rst_n low SHALL force IDLE immediately, clear the latched request and merge register, and drive every output to 0.
REQ-029 Reset during RMW_READ or RMW_WRITE before the write edge SHALL leave memory unmodified; no Mem_write is issued after release.

Structure
REQ-030 Package mips_mem_pkg SHALL hold the size encodings, the FSM state enum and the MEM_WORDS default.
REQ-031 One combinational sub-module, lsu_align, SHALL perform lane extract/extend and lane merge.

Verification (memory word 5 preloaded 0x8899AABB)
REQ-032 lb 0x15 signed -> Mem_read cycle 0, Stall 1 cycle, cycle 1 Load_valid=1, Load_data=0xFFFFFFAA.
REQ-033 lhu 0x16 -> Load_data=0x00008899 in cycle 1; lh same address -> 0xFFFF8899.
REQ-034 sb 0x000000CC to 0x14 -> Mem_read cycle 0, Mem_write cycle 2 with Mem_address=5, Mem_wdata=0x8899AACC, Stall high cycles 0-1.
REQ-035 sw 0x12345678 to 0x20 -> Mem_write cycle 0, Mem_address=8, Stall=0; lw 0x22 -> Misalign pulse, no strobes; lw 0xFA0 -> Range_err pulse.
REQ-036 sb to 0x14, Rst_n low during RMW_READ -> no Mem_write, word 5 still 0x8899AABB, all outputs 0, IDLE after release.
